channel_impair: RTL and testbench
=================================

Name: channel_impair

Overview:
- Parametrised successor to the single-wire channel block. Sits between the transmitter framer and the receiver deframer in the communication experiment datapath.
- Carries a valid-qualified data word through a fixed-latency pipeline.
- Applies a selectable impairment: pass, random single-bit errors, or periodic burst blanking. The manual interrupt override is kept.
- Counts corrupted words and drives a stretched LED so short events are visible on the board.

Parameters:
- DATA_W, 8: data word width; power of two, 2..64.
- DELAY, 2: pipeline latency in cycles; minimum 1.
- LFSR_SEED, 16'hACE1: LFSR reset value; must be nonzero.
- LED_HOLD, 1000000: cycles the LED stays lit after the last corrupted word.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- valid_i  input  1  data_i qualifier
- data_i  input  DATA_W  transmitted word
- mode  input  2  impairment select: 00 PASS, 01 BER, 10 BURST, 11 reserved (behaves as PASS)
- channel_interrupt  input  1  forces the data word to zero, overriding mode
- err_thresh  input  16  BER threshold
- burst_len  input  8  blanked cycles per burst period
- burst_period  input  8  burst period in cycles
- valid_o  output  1  delayed valid_i
- data_o  output  DATA_W  delayed, impaired word
- channel_led  output  1  impairment indicator
- err_count  output  16  saturating count of corrupted words

Behaviour:
- Reset: only one clock; reset is synchronous and active-high. During reset:
  - All delay-line stages clear, so valid_o=0 and data_o=0.
  - lfsr=LFSR_SEED, phase=0, err_count=0, hold=0, channel_led=0.
- Reset mid-stream discards every in-flight word.
- Latency: a word sampled with valid_i=1 at cycle t appears at valid_o/data_o at cycle t+DELAY.
- Valid is always propagated unchanged; no word is ever dropped or inserted. There is no backpressure.
- Impairment mask is computed combinationally at the input and registered into stage 1. Stages 2..DELAY are plain registers.
- LFSR:
  - 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1.
  - Shifts only on cycles with valid_i=1, in every mode.
- BER mode:
  - A word is hit when valid_i=1 and lfsr <= err_thresh, using the pre-shift lfsr value.
  - A hit flips one bit, at index lfsr[log2(DATA_W)-1:0].
  - err_thresh=0 never hits, because the LFSR is never zero. err_thresh=16'hFFFF hits every word.
- BURST mode:
  - phase is an 8-bit counter that runs every cycle regardless of valid_i or mode. It wraps to 0 when phase == burst_period-1.
  - A word is blanked to zero when phase < burst_len.
  - burst_period=0: phase held at 0 and no blanking.
  - burst_len >= burst_period: every word is blanked.
- channel_interrupt=1: data forced to zero in every mode; BER/BURST effects are ignored for that word.
- Mode or threshold changes apply to the word sampled in the same cycle. phase and lfsr are not reset by a mode change.
- err_count:
  - +1 on each cycle with valid_i=1 whose stage-1 data differs from data_i. A zero blanked to zero does not count.
  - Saturates at 16'hFFFF. Cleared only by rst.
- channel_led:
  - Registered; equals (channel_interrupt | hold != 0) from the previous cycle.
  - hold loads LED_HOLD on a counted corruption or whenever channel_interrupt=1; otherwise it decrements to 0.
  - Reload while nonzero restarts the hold.
- Simultaneous corruption and saturation: err_count stays at 16'hFFFF; the LED still reloads.

Decomposition:
- Package channel_pkg holds:
  - mode encodings MODE_PASS, MODE_BER, MODE_BURST;
  - LFSR_W=16 and the tap mask;
  - the err_count width.
- Sub-module channel_lfsr (seed parameter, enable input, 16-bit state output), reusable by the PRBS generator.

Test Plan:
1. PASS, DELAY=2, words 8'h00..8'h0F with valid_i=1 -> data_o equal to the input at t+2, valid_o matching, err_count=0, channel_led=0.
2. channel_interrupt=1 for 3 cycles during a stream of 8'hA5 -> three 8'h00 words with valid_o=1, err_count=3, LED lit for LED_HOLD (use LED_HOLD=20 in the bench) after interrupt falls.
3. BER, err_thresh=16'hFFFF, 100 words of 8'h00 -> every output has exactly one bit set, with index matching the reference LFSR model; err_count=100. Same run with err_thresh=0 -> output all zero, err_count=0.
4. BURST, burst_period=10, burst_len=3, continuous 8'hFF -> repeating pattern of 3 zero words then 7 8'hFF words, aligned to phase from reset. burst_period=0 -> no blanking.
5. err_count saturation: force 70000 corrupted words -> err_count holds 16'hFFFF.
6. rst asserted for 1 cycle mid-stream with DELAY=4 -> valid_o=0 for the next 4 cycles, err_count=0, the LFSR sequence restarts from LFSR_SEED.

Source files
------------

// File: rtl/channel_pkg.sv
// Shared definitions for the channel impairment block and its LFSR.
package channel_pkg;

    typedef enum logic [1:0] {
        MODE_PASS  = 2'b00,
        MODE_BER   = 2'b01,
        MODE_BURST = 2'b10,
        MODE_RSVD  = 2'b11
    } mode_e;

    localparam int unsigned LFSR_W = 16;

    // Right-shifting Fibonacci form: feedback is the XOR of state bits 0,2,3,5,
    // which realises x^16 + x^14 + x^13 + x^11 + 1.
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'h002D;

    localparam int unsigned ERR_W = 16;

endpackage

// File: rtl/channel_lfsr.sv
// 16-bit Fibonacci LFSR that advances only when enabled.
module channel_lfsr
    import channel_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic [LFSR_W-1:0] state
);

    // Shift right, feedback into the MSB.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SEED;
        end else if (en) begin
            state <= {^(state & LFSR_TAPS), state[LFSR_W-1:1]};
        end
    end

endmodule

// File: rtl/channel_impair.sv
// Fixed-latency channel with selectable impairment, corruption counter and
// stretched activity LED.
module channel_impair
    import channel_pkg::*;
#(
    parameter int unsigned       DATA_W    = 8,
    parameter int unsigned       DELAY     = 2,
    parameter logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1,
    parameter int unsigned       LED_HOLD  = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [1:0]        mode,
    input  logic              channel_interrupt,
    input  logic [15:0]       err_thresh,
    input  logic [7:0]        burst_len,
    input  logic [7:0]        burst_period,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic              channel_led,
    output logic [ERR_W-1:0]  err_count
);

    localparam int unsigned IDX_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int unsigned HOLD_W = (LED_HOLD > 0) ? $clog2(LED_HOLD + 1) : 1;

    logic [LFSR_W-1:0] lfsr;
    logic [7:0]        phase;
    logic [HOLD_W-1:0] hold;
    logic [DATA_W-1:0] impaired;
    logic              ber_hit;
    logic              blank;
    logic              corrupt;
    mode_e             mode_sel;
    logic              valid_q [DELAY];
    logic [DATA_W-1:0] data_q  [DELAY];

    assign mode_sel = mode_e'(mode);

    channel_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .en    (valid_i),
        .state (lfsr)
    );

    // Impairment mask applied to the incoming word before stage 1.
    always_comb begin
        ber_hit  = valid_i && (lfsr <= err_thresh);
        blank    = (burst_period != 8'd0) && (phase < burst_len);
        impaired = data_i;
        case (mode_sel)
            MODE_BER:   if (ber_hit) impaired = data_i ^ (DATA_W'(1) << lfsr[IDX_W-1:0]);
            MODE_BURST: if (blank) impaired = '0;
            default:    impaired = data_i;
        endcase
        if (channel_interrupt) begin
            impaired = '0;
        end
        corrupt = valid_i && (impaired != data_i);
    end

    // Free-running burst phase, wrapping at burst_period-1.
    always_ff @(posedge clk) begin
        if (rst || burst_period == 8'd0 || phase == burst_period - 8'd1) begin
            phase <= '0;
        end else begin
            phase <= phase + 8'd1;
        end
    end

    // Delay line: stage 0 captures the impaired word, later stages just shift.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DELAY; i++) begin
                valid_q[i] <= 1'b0;
                data_q[i]  <= '0;
            end
        end else begin
            valid_q[0] <= valid_i;
            data_q[0]  <= impaired;
            for (int unsigned i = 1; i < DELAY; i++) begin
                valid_q[i] <= valid_q[i-1];
                data_q[i]  <= data_q[i-1];
            end
        end
    end

    assign valid_o = valid_q[DELAY-1];
    assign data_o  = data_q[DELAY-1];

    // Saturating count of words altered by the channel.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_count <= '0;
        end else if (corrupt && err_count != '1) begin
            err_count <= err_count + ERR_W'(1);
        end
    end

    // LED hold timer, reloaded by corruption or interrupt; LED follows one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold        <= '0;
            channel_led <= 1'b0;
        end else begin
            if (corrupt || channel_interrupt) begin
                hold <= HOLD_W'(LED_HOLD);
            end else if (hold != '0) begin
                hold <= hold - HOLD_W'(1);
            end
            channel_led <= channel_interrupt | (hold != '0);
        end
    end

endmodule

// File: tb/tb_channel_impair.sv
// Directed self-checking bench for channel_impair (DELAY=2 and DELAY=4 instances).
module tb_channel_impair;

    logic        clk = 1'b0;
    logic        rst, valid_i, channel_interrupt;
    logic [7:0]  data_i, burst_len, burst_period;
    logic [1:0]  mode;
    logic [15:0] err_thresh;
    logic        valid_o, channel_led, valid_o4, channel_led4;
    logic [7:0]  data_o, data_o4;
    logic [15:0] err_count, err_count4;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    channel_impair #(
        .DATA_W(8), .DELAY(2), .LFSR_SEED(16'hACE1), .LED_HOLD(20)
    ) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .data_i(data_i), .mode(mode),
        .channel_interrupt(channel_interrupt), .err_thresh(err_thresh),
        .burst_len(burst_len), .burst_period(burst_period), .valid_o(valid_o),
        .data_o(data_o), .channel_led(channel_led), .err_count(err_count)
    );

    channel_impair #(
        .DATA_W(8), .DELAY(4), .LFSR_SEED(16'hACE1), .LED_HOLD(20)
    ) dut4 (
        .clk(clk), .rst(rst), .valid_i(valid_i), .data_i(data_i), .mode(mode),
        .channel_interrupt(channel_interrupt), .err_thresh(err_thresh),
        .burst_len(burst_len), .burst_period(burst_period), .valid_o(valid_o4),
        .data_o(data_o4), .channel_led(channel_led4), .err_count(err_count4)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
    endfunction

    task automatic test_reset();
        valid_i = 1'b1; data_i = 8'h5A; channel_interrupt = 1'b1;
        apply_reset();
        channel_interrupt = 1'b0; valid_i = 1'b0;
        checks++; if (valid_o !== 1'b0 || data_o !== 8'h00) begin errors++;
            $display("FAIL reset_out: valid_o=%b data_o=%h, want 0/00", valid_o, data_o); end
        checks++; if (err_count !== 16'h0 || channel_led !== 1'b0) begin errors++;
            $display("FAIL reset_cnt: err_count=%h led=%b, want 0/0", err_count, channel_led); end
        checks++; if (valid_o4 !== 1'b0 || data_o4 !== 8'h00 || err_count4 !== 16'h0) begin errors++;
            $display("FAIL reset_d4: valid=%b data=%h cnt=%h, want 0/00/0", valid_o4, data_o4, err_count4); end
    endtask

    task automatic test_pass();
        logic [7:0] exp_d [16];
        mode = 2'b00; channel_interrupt = 1'b0;
        apply_reset();
        valid_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            data_i = 8'(i); exp_d[i] = 8'(i);
            step();
            if (i >= 1) begin
                checks++; if (valid_o !== 1'b1 || data_o !== exp_d[i-1]) begin errors++;
                    $display("FAIL pass_word%0d: valid=%b data=%h, want 1/%h", i-1, valid_o, data_o, exp_d[i-1]); end
            end
        end
        valid_i = 1'b0; data_i = 8'h00;
        step();
        checks++; if (valid_o !== 1'b1 || data_o !== 8'h0F) begin errors++;
            $display("FAIL pass_last: valid=%b data=%h, want 1/0f", valid_o, data_o); end
        step();
        checks++; if (valid_o !== 1'b0) begin errors++;
            $display("FAIL pass_idle: valid=%b, want 0", valid_o); end
        checks++; if (err_count !== 16'h0 || channel_led !== 1'b0) begin errors++;
            $display("FAIL pass_cnt: err_count=%h led=%b, want 0/0", err_count, channel_led); end
    endtask

    task automatic test_interrupt();
        logic [7:0] exp_d [30];
        logic       exp_led;
        mode = 2'b00; channel_interrupt = 1'b0;
        apply_reset();
        valid_i = 1'b1; data_i = 8'hA5;
        for (int i = 0; i < 30; i++) begin
            channel_interrupt = (i >= 3 && i <= 5);
            exp_d[i] = channel_interrupt ? 8'h00 : 8'hA5;
            exp_led = (i >= 3 && i <= 25);
            step();
            if (i >= 1) begin
                checks++; if (valid_o !== 1'b1 || data_o !== exp_d[i-1]) begin errors++;
                    $display("FAIL intr_word%0d: valid=%b data=%h, want 1/%h", i-1, valid_o, data_o, exp_d[i-1]); end
            end
            checks++; if (channel_led !== exp_led) begin errors++;
                $display("FAIL intr_led%0d: led=%b, want %b", i, channel_led, exp_led); end
        end
        channel_interrupt = 1'b0; valid_i = 1'b0;
        step();
        checks++; if (err_count !== 16'd3) begin errors++;
            $display("FAIL intr_cnt: err_count=%0d, want 3", err_count); end
    endtask

    task automatic test_ber();
        logic [7:0]  exp_d [100];
        logic [15:0] l;
        int          hits;
        mode = 2'b01; channel_interrupt = 1'b0; err_thresh = 16'hFFFF;
        apply_reset();
        valid_i = 1'b1; data_i = 8'h00; l = 16'hACE1;
        for (int i = 0; i < 100; i++) begin
            exp_d[i] = 8'd1 << l[2:0];
            l = lfsr_next(l);
            step();
            if (i >= 1) begin
                checks++; if (valid_o !== 1'b1 || data_o !== exp_d[i-1]) begin errors++;
                    $display("FAIL ber_all%0d: valid=%b data=%h, want 1/%h", i-1, valid_o, data_o, exp_d[i-1]); end
            end
        end
        valid_i = 1'b0;
        step();
        checks++; if (data_o !== exp_d[99]) begin errors++;
            $display("FAIL ber_all_last: data=%h, want %h", data_o, exp_d[99]); end
        checks++; if (err_count !== 16'd100) begin errors++;
            $display("FAIL ber_all_cnt: err_count=%0d, want 100", err_count); end

        err_thresh = 16'h0000;
        apply_reset();
        valid_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (i >= 1) begin
                checks++; if (data_o !== 8'h00) begin errors++;
                    $display("FAIL ber_none%0d: data=%h, want 00", i-1, data_o); end
            end
        end
        valid_i = 1'b0;
        step();
        checks++; if (err_count !== 16'd0) begin errors++;
            $display("FAIL ber_none_cnt: err_count=%0d, want 0", err_count); end

        err_thresh = 16'h8000;
        apply_reset();
        valid_i = 1'b1; l = 16'hACE1; hits = 0;
        for (int i = 0; i < 40; i++) begin
            exp_d[i] = (l <= err_thresh) ? (8'd1 << l[2:0]) : 8'h00;
            if (l <= err_thresh) hits++;
            l = lfsr_next(l);
            step();
            if (i >= 1) begin
                checks++; if (data_o !== exp_d[i-1]) begin errors++;
                    $display("FAIL ber_half%0d: data=%h, want %h", i-1, data_o, exp_d[i-1]); end
            end
        end
        valid_i = 1'b0;
        step();
        checks++; if (err_count !== 16'(hits)) begin errors++;
            $display("FAIL ber_half_cnt: err_count=%0d, want %0d", err_count, hits); end
    endtask

    task automatic test_burst();
        logic [7:0] exp_d [48];
        mode = 2'b10; channel_interrupt = 1'b0; err_thresh = 16'h0000;
        burst_period = 8'd10; burst_len = 8'd3;
        valid_i = 1'b1; data_i = 8'hFF;
        apply_reset();
        for (int i = 0; i < 48; i++) begin
            if (i < 30) begin
                burst_period = 8'd10; burst_len = 8'd3;
                exp_d[i] = ((i % 10) < 3) ? 8'h00 : 8'hFF;
            end else if (i < 40) begin
                burst_period = 8'd0; burst_len = 8'd3;
                exp_d[i] = 8'hFF;
            end else begin
                burst_period = 8'd4; burst_len = 8'd4;
                exp_d[i] = 8'h00;
            end
            step();
            if (i >= 1) begin
                checks++; if (valid_o !== 1'b1 || data_o !== exp_d[i-1]) begin errors++;
                    $display("FAIL burst_word%0d: valid=%b data=%h, want 1/%h", i-1, valid_o, data_o, exp_d[i-1]); end
            end
        end
        valid_i = 1'b0;
        step();
        checks++; if (data_o !== 8'h00) begin errors++;
            $display("FAIL burst_last: data=%h, want 00", data_o); end
        checks++; if (err_count !== 16'd17) begin errors++;
            $display("FAIL burst_cnt: err_count=%0d, want 17", err_count); end
        burst_period = 8'd0; burst_len = 8'd0;
    endtask

    task automatic test_saturation();
        mode = 2'b00; channel_interrupt = 1'b0;
        apply_reset();
        valid_i = 1'b1; data_i = 8'hA5; channel_interrupt = 1'b1;
        repeat (65534) step();
        checks++; if (err_count !== 16'hFFFE) begin errors++;
            $display("FAIL sat_near: err_count=%h, want fffe", err_count); end
        repeat (70000 - 65534) step();
        checks++; if (err_count !== 16'hFFFF) begin errors++;
            $display("FAIL sat_hold: err_count=%h, want ffff", err_count); end
        checks++; if (channel_led !== 1'b1) begin errors++;
            $display("FAIL sat_led: led=%b, want 1", channel_led); end
        channel_interrupt = 1'b0; valid_i = 1'b0;
    endtask

    task automatic test_mid_reset();
        logic [7:0]  exp_d [10];
        logic [15:0] l;
        mode = 2'b01; channel_interrupt = 1'b0; err_thresh = 16'hFFFF;
        apply_reset();
        valid_i = 1'b1; data_i = 8'h00;
        repeat (6) step();
        checks++; if (valid_o4 !== 1'b1 || err_count4 !== 16'd6) begin errors++;
            $display("FAIL mid_pre: valid=%b cnt=%0d, want 1/6", valid_o4, err_count4); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (valid_o4 !== 1'b0 || data_o4 !== 8'h00 || err_count4 !== 16'd0) begin errors++;
            $display("FAIL mid_rst: valid=%b data=%h cnt=%0d, want 0/00/0", valid_o4, data_o4, err_count4); end
        l = 16'hACE1;
        for (int k = 1; k <= 10; k++) begin
            exp_d[k-1] = 8'd1 << l[2:0];
            l = lfsr_next(l);
            step();
            if (k <= 3) begin
                checks++; if (valid_o4 !== 1'b0) begin errors++;
                    $display("FAIL mid_gap%0d: valid=%b, want 0", k, valid_o4); end
            end else begin
                checks++; if (valid_o4 !== 1'b1 || data_o4 !== exp_d[k-4]) begin errors++;
                    $display("FAIL mid_word%0d: valid=%b data=%h, want 1/%h", k-4, valid_o4, data_o4, exp_d[k-4]); end
            end
        end
        valid_i = 1'b0;
    endtask

    initial begin
        rst = 1'b1; valid_i = 1'b0; data_i = 8'h00; mode = 2'b00;
        channel_interrupt = 1'b0; err_thresh = 16'h0000;
        burst_len = 8'd0; burst_period = 8'd0;
        test_reset();
        test_pass();
        test_interrupt();
        test_ber();
        test_burst();
        test_saturation();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
